data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-side memory responder for the single-cycle MIPS core: it receives the core's memwrite, address (ALU result) and writedata, and returns readdata in the same cycle. The address space covers a word RAM and a small memory-mapped I/O page: GPIO, a free-running cycle counter, and a store-trace FIFO status word. Every RAM store is also captured in a trace FIFO that a debug port drains independently, complementing the core's register-file debug outputs.

## Interface
- RAM_AW, 6, RAM word-address width (2^RAM_AW words of 32 bits).
- TRACE_AW, 3, trace FIFO address width; depth = 2^TRACE_AW entries.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- memwrite  in  1  store strobe from the core; a write occurs on each rising edge where it is high.
- addr  in  32  byte address from the core's ALU result; addr[1:0] ignored.
- writedata  in  32  store data.
- readdata  out  32  load data, combinational from addr and current state.
- gpio_in  in  8  external inputs, asynchronous to the core's timing.
- gpio_out  out  8  GPIO output register.
- dbg_pop  in  1  debug side consumes the head trace entry.
- dbg_valid  out  1  trace FIFO non-empty.
- dbg_addr  out  32  head entry store address (addr[31:2], 2'b00).
- dbg_data  out  32  head entry store data.
- dbg_count  out  TRACE_AW+1  current FIFO occupancy.

## Operation
- RAM region: addr[31:16] == 16'h0000 and addr[15:RAM_AW+2] == 0. Word index is addr[RAM_AW+1:2].
- I/O page: addr[31:4] == 28'hFFFF_FFF. Register index is addr[3:2].
  - 0xFFFF_FFF0 GPIO_OUT: read/write; bits [7:0] used, reads zero-extended.
  - 0xFFFF_FFF4 GPIO_IN: read-only; value after the 2-flop synchronizer, zero-extended.
  - 0xFFFF_FFF8 CYCLE: read/write.
  - 0xFFFF_FFFC TRACE_STAT: read returns {overflow, 23'b0, dbg_count zero-extended to 8 bits}. Any write clears overflow.
- Any other address: reads return 0; writes are ignored and not traced.
- Loads are combinational. readdata reflects RAM/register contents before the current edge, so there is no read-after-write forwarding within the same cycle.
- RAM store: the word is written at the edge, and {addr, writedata} is pushed into the trace FIFO.
- CYCLE counter increments by 1 each cycle and wraps from 0xFFFF_FFFF to 0. A store to CYCLE loads writedata and takes priority over the increment, so the next read returns writedata.
- Trace FIFO uses separate read and write pointers plus a count.
  - Push when full with no pop: the entry is dropped and sticky overflow is set.
  - Push and pop in the same cycle when full: both happen, no drop, count unchanged.
  - Push and pop in the same cycle when empty: push only; the pop is ignored.
  - Pop when empty: ignored, no state change.
  - A TRACE_STAT write that coincides with a dropped push: overflow ends set, because set wins over clear.
- dbg_addr and dbg_data show the head entry whenever dbg_valid = 1. When empty they hold the last value and are don't-care.

## Timing
- Reset values:
  - gpio_out = 0, CYCLE = 0, overflow = 0.
  - FIFO pointers and count = 0, so dbg_valid = 0 and dbg_count = 0.
  - Synchronizer flops = 0.
  - RAM contents are not cleared.
- Reset is honored mid-operation. An asserted reset overrides any simultaneous store, push or pop; the RAM write enable is gated by !reset.
- Load latency: 0 cycles (combinational).
- Store latency: visible to loads on the next cycle.
- Trace entry latency: dbg_valid rises the cycle after the store edge.
- GPIO_IN latency: a change on gpio_in is readable 2 edges later.
- CYCLE reads N at the Nth cycle after reset release, counting the first post-reset edge as 1.
- Pop takes effect at the edge where dbg_pop = 1 and the FIFO is non-empty; the next entry appears after that edge.

## Test plan
- Reset, then store 0x1234_5678 to 0x0000_0010 and load the same address next cycle -> readdata = 0x1234_5678; dbg_valid = 1, dbg_addr = 0x10, dbg_data = 0x1234_5678, dbg_count = 1.
- Store to 0xFFFF_FFF0 with 0xA5A5_A5C3 -> gpio_out = 0xC3, and a GPIO_OUT read returns 0x0000_00C3. Drive gpio_in = 0x5A -> GPIO_IN read returns 0x5A exactly 2 edges later and 0 before that.
- Store 0xFFFF_FFFE to CYCLE -> reads return 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on successive cycles (wrap).
- With TRACE_AW = 3, perform 9 RAM stores with no pops -> dbg_count = 8 and TRACE_STAT = 0x8000_0008. The 9th store's data is in RAM but not in the FIFO. Pop all 8 -> entries emerge in store order, then dbg_valid = 0. Write TRACE_STAT -> reads 0.
- With the FIFO full, one store coinciding with dbg_pop = 1 -> count stays 8, overflow stays 0, and the new entry appears last.
- Store to 0x0001_0000 and to 0xFFFF_FF00 -> no RAM change, no trace push, and loads of both addresses return 0. Assert reset mid-sequence while a store is in flight -> the store is lost, and all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : Core-to-data-memory bus: store strobe, address, store/load data.
// Revision : 1.0
// ============================================================================
interface data_mem_responder_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, output addr, output writedata, input readdata);
    modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data RAM plus GPIO/cycle-counter/trace-status I/O page, with a
//            store-trace FIFO drained through a debug port.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int RAM_AW   = 6,
    parameter int TRACE_AW = 3
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    data_mem_responder_if.slave       bus,
    input  wire logic [7:0]           gpio_in,
    output logic      [7:0]           gpio_out,
    input  wire logic                 dbg_pop,
    output logic                      dbg_valid,
    output logic      [31:0]          dbg_addr,
    output logic      [31:0]          dbg_data,
    output logic      [TRACE_AW:0]    dbg_count
);

    localparam int                DEPTH      = 2 ** TRACE_AW;
    localparam logic [TRACE_AW:0] FULL_COUNT = (TRACE_AW + 1)'(DEPTH);
    localparam logic [1:0]        IDX_GPO    = 2'd0;
    localparam logic [1:0]        IDX_GPI    = 2'd1;
    localparam logic [1:0]        IDX_CYCLE  = 2'd2;
    localparam logic [1:0]        IDX_STAT   = 2'd3;

    logic [31:0] ram_mem        [2 ** RAM_AW];
    logic [29:0] trace_addr_mem [DEPTH];
    logic [31:0] trace_data_mem [DEPTH];

    logic [7:0]          gpio_out_q, gpio_out_d;
    logic [7:0]          sync1_q, sync1_d;
    logic [7:0]          sync2_q, sync2_d;
    logic [31:0]         cycle_q, cycle_d;
    logic                overflow_q, overflow_d;
    logic [TRACE_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [TRACE_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TRACE_AW:0]   count_q, count_d;

    logic              is_ram, is_io, store_io, push_req;
    logic              fifo_full, fifo_empty, do_push, do_pop, drop;
    logic [1:0]        io_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       rdata;
    logic              unused_addr_bits;

    assign is_ram     = (bus.addr[31:16] == 16'h0000) &&
                        ((bus.addr[15:0] >> (RAM_AW + 2)) == 16'h0000);
    assign is_io      = (bus.addr[31:4] == 28'hFFF_FFFF);
    assign io_idx     = bus.addr[3:2];
    assign ram_idx    = bus.addr[RAM_AW+1:2];
    assign store_io   = bus.memwrite && is_io;
    assign push_req   = bus.memwrite && is_ram;
    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign do_pop     = dbg_pop && !fifo_empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign drop       = push_req && fifo_full && !do_pop;
    assign unused_addr_bits = ^bus.addr[1:0];

    always_comb begin
        gpio_out_d = gpio_out_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        cycle_d    = cycle_q + 32'd1;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (store_io && io_idx == IDX_GPO)   gpio_out_d = bus.writedata[7:0];
        if (store_io && io_idx == IDX_CYCLE) cycle_d    = bus.writedata;

        // Set beats clear so a drop is never hidden by a concurrent clear.
        if (drop)                               overflow_d = 1'b1;
        else if (store_io && io_idx == IDX_STAT) overflow_d = 1'b0;

        if (do_push) wr_ptr_d = wr_ptr_q + TRACE_AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + TRACE_AW'(1);

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (TRACE_AW + 1)'(1);
            2'b01:   count_d = count_q - (TRACE_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage arrays are not reset; writes are suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (push_req && !reset) ram_mem[ram_idx] <= bus.writedata;
        if (do_push && !reset) begin
            trace_addr_mem[wr_ptr_q] <= bus.addr[31:2];
            trace_data_mem[wr_ptr_q] <= bus.writedata;
        end
    end

    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = ram_mem[ram_idx];
        end else if (is_io) begin
            unique case (io_idx)
                IDX_GPO:   rdata = {24'h0, gpio_out_q};
                IDX_GPI:   rdata = {24'h0, sync2_q};
                IDX_CYCLE: rdata = cycle_q;
                default:   rdata = {overflow_q, 23'h0, 8'(count_q)};
            endcase
        end
    end

    assign bus.readdata = rdata;
    assign gpio_out     = gpio_out_q;
    assign dbg_valid    = !fifo_empty;
    assign dbg_addr     = {trace_addr_mem[rd_ptr_q], 2'b00};
    assign dbg_data     = trace_data_mem[rd_ptr_q];
    assign dbg_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench; trace entries tracked in a scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  gpio_in = 8'h00;
    logic [7:0]  gpio_out;
    logic        dbg_pop = 1'b0;
    logic        dbg_valid;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_data;
    logic [3:0]  dbg_count;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] sb_q[$];
    logic        ovf_m = 1'b0;

    data_mem_responder_if bus();

    data_mem_responder #(.RAM_AW(6), .TRACE_AW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .dbg_pop   (dbg_pop),
        .dbg_valid (dbg_valid),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_count (dbg_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One store cycle; updates the trace model (push if room, else overflow).
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = 1'b1;
        bus.addr      = a;
        bus.writedata = d;
        if (a[31:16] == 16'h0 && a[15:8] == 8'h0) begin
            if (sb_q.size() < 8) sb_q.push_back({a[31:2], 2'b00, d});
            else                 ovf_m = 1'b1;
        end
        tick();
        bus.memwrite = 1'b0;
        dbg_pop      = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] cyc;
        tick();
        tick();
        vectors++;
        if (gpio_out !== 8'h00 || dbg_valid !== 1'b0 || dbg_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gpio=%h valid=%b count=%0d required 00/0/0", gpio_out, dbg_valid, dbg_count);
        end
        reset = 1'b0;
        bus.addr = 32'hFFFF_FFF8;
        #1;
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL cycle_at_release: got %h required 00000000", bus.readdata);
        end
        tick();
        cyc = bus.readdata;
        vectors++;
        if (cyc !== 32'h1) begin
            miscompares++;
            $display("FAIL cycle_first_edge: got %h required 00000001", cyc);
        end
    endtask

    task automatic test_ram_store();
        logic [63:0] exp;
        store(32'h0000_0010, 32'h1234_5678);
        bus.addr = 32'h0000_0010;
        #1;
        vectors++;
        if (bus.readdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL ram_load: got %h required 12345678", bus.readdata);
        end
        vectors++;
        if (dbg_valid !== 1'b1 || dbg_addr !== 32'h10 || dbg_data !== 32'h1234_5678 || dbg_count !== 4'd1) begin
            miscompares++;
            $display("FAIL trace_head: got v=%b a=%h d=%h c=%0d required 1/00000010/12345678/1", dbg_valid, dbg_addr, dbg_data, dbg_count);
        end
        store(32'h0000_0014, 32'hAAAA_0001);
        // Same-cycle load during a store must see the old word.
        bus.memwrite  = 1'b1;
        bus.addr      = 32'h0000_0014;
        bus.writedata = 32'hBBBB_0002;
        #1;
        vectors++;
        if (bus.readdata !== 32'hAAAA_0001) begin
            miscompares++;
            $display("FAIL no_forwarding: got %h required aaaa0001", bus.readdata);
        end
        sb_q.push_back({32'h0000_0014, 32'hBBBB_0002});
        tick();
        bus.memwrite = 1'b0;
        #1;
        vectors++;
        if (bus.readdata !== 32'hBBBB_0002) begin
            miscompares++;
            $display("FAIL store_visible_next: got %h required bbbb0002", bus.readdata);
        end
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            vectors++;
            if (dbg_valid !== 1'b1 || dbg_addr !== exp[63:32] || dbg_data !== exp[31:0]) begin
                miscompares++;
                $display("FAIL drain_basic: got %b %h %h required 1 %h %h", dbg_valid, dbg_addr, dbg_data, exp[63:32], exp[31:0]);
            end
            dbg_pop = 1'b1;
            tick();
            dbg_pop = 1'b0;
        end
    endtask

    task automatic test_gpio();
        store(32'hFFFF_FFF0, 32'hA5A5_A5C3);
        bus.addr = 32'hFFFF_FFF0;
        #1;
        vectors++;
        if (gpio_out !== 8'hC3 || bus.readdata !== 32'h0000_00C3) begin
            miscompares++;
            $display("FAIL gpio_out: got pin=%h rd=%h required c3/000000c3", gpio_out, bus.readdata);
        end
        vectors++;
        if (dbg_count !== 4'd0) begin
            miscompares++;
            $display("FAIL io_not_traced: got count %0d required 0", dbg_count);
        end
        gpio_in  = 8'h5A;
        bus.addr = 32'hFFFF_FFF4;
        #1;
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL gpio_in_edge0: got %h required 00000000", bus.readdata);
        end
        tick();
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL gpio_in_edge1: got %h required 00000000", bus.readdata);
        end
        tick();
        vectors++;
        if (bus.readdata !== 32'h5A) begin
            miscompares++;
            $display("FAIL gpio_in_edge2: got %h required 0000005a", bus.readdata);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] exp_tab [3];
        exp_tab[0] = 32'hFFFF_FFFE;
        exp_tab[1] = 32'hFFFF_FFFF;
        exp_tab[2] = 32'h0000_0000;
        store(32'hFFFF_FFF8, 32'hFFFF_FFFE);
        bus.addr = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.readdata !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL cycle_wrap[%0d]: got %h required %h", i, bus.readdata, exp_tab[i]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp;
        for (int i = 0; i < 9; i++) store(32'h20 + 32'(4 * i), 32'h1000 + 32'(i));
        bus.addr = 32'hFFFF_FFFC;
        #1;
        vectors++;
        if (dbg_count !== 4'(sb_q.size()) || bus.readdata !== {ovf_m, 23'h0, 8'(sb_q.size())}) begin
            miscompares++;
            $display("FAIL overflow_stat: got count=%0d stat=%h required %0d/%h", dbg_count, bus.readdata, sb_q.size(), {ovf_m, 23'h0, 8'(sb_q.size())});
        end
        bus.addr = 32'h0000_0040;
        #1;
        vectors++;
        if (bus.readdata !== 32'h1008) begin
            miscompares++;
            $display("FAIL ninth_in_ram: got %h required 00001008", bus.readdata);
        end
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            vectors++;
            if (dbg_valid !== 1'b1 || dbg_addr !== exp[63:32] || dbg_data !== exp[31:0]) begin
                miscompares++;
                $display("FAIL drain_overflow: got %b %h %h required 1 %h %h", dbg_valid, dbg_addr, dbg_data, exp[63:32], exp[31:0]);
            end
            dbg_pop = 1'b1;
            tick();
            dbg_pop = 1'b0;
        end
        vectors++;
        if (dbg_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_after_drain: got valid %b required 0", dbg_valid);
        end
        store(32'hFFFF_FFFC, 32'h0);
        ovf_m = 1'b0;
        bus.addr = 32'hFFFF_FFFC;
        #1;
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL stat_clear: got %h required 00000000", bus.readdata);
        end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp;
        for (int i = 0; i < 8; i++) store(32'h80 + 32'(4 * i), 32'h2000 + 32'(i));
        exp = sb_q.pop_front();
        vectors++;
        if (dbg_addr !== exp[63:32] || dbg_data !== exp[31:0]) begin
            miscompares++;
            $display("FAIL full_head: got %h %h required %h %h", dbg_addr, dbg_data, exp[63:32], exp[31:0]);
        end
        dbg_pop = 1'b1;
        store(32'h0000_00A0, 32'h2FFF);
        bus.addr = 32'hFFFF_FFFC;
        #1;
        vectors++;
        if (dbg_count !== 4'd8 || bus.readdata !== 32'h0000_0008) begin
            miscompares++;
            $display("FAIL full_push_pop: got count=%0d stat=%h required 8/00000008", dbg_count, bus.readdata);
        end
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            vectors++;
            if (dbg_valid !== 1'b1 || dbg_addr !== exp[63:32] || dbg_data !== exp[31:0]) begin
                miscompares++;
                $display("FAIL drain_full: got %b %h %h required 1 %h %h", dbg_valid, dbg_addr, dbg_data, exp[63:32], exp[31:0]);
            end
            dbg_pop = 1'b1;
            tick();
            dbg_pop = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        dbg_pop = 1'b1;
        store(32'h0000_00B0, 32'h3333);
        vectors++;
        if (dbg_count !== 4'd1 || dbg_valid !== 1'b1 || dbg_data !== 32'h3333) begin
            miscompares++;
            $display("FAIL empty_push_pop: got c=%0d v=%b d=%h required 1/1/00003333", dbg_count, dbg_valid, dbg_data);
        end
        void'(sb_q.pop_front());
        dbg_pop = 1'b1;
        tick();
        tick();
        dbg_pop = 1'b0;
        vectors++;
        if (dbg_count !== 4'd0 || dbg_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_when_empty: got c=%0d v=%b required 0/0", dbg_count, dbg_valid);
        end
    endtask

    task automatic test_unmapped();
        store(32'h0000_0000, 32'hCAFE_F00D);
        void'(sb_q.pop_front());
        dbg_pop = 1'b1;
        tick();
        dbg_pop = 1'b0;
        store(32'h0001_0000, 32'hDEAD_0001);
        store(32'hFFFF_FF00, 32'hDEAD_0002);
        vectors++;
        if (dbg_count !== 4'd0) begin
            miscompares++;
            $display("FAIL unmapped_no_trace: got count %0d required 0", dbg_count);
        end
        bus.addr = 32'h0001_0000;
        #1;
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_load_a: got %h required 00000000", bus.readdata);
        end
        bus.addr = 32'hFFFF_FF00;
        #1;
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_load_b: got %h required 00000000", bus.readdata);
        end
        bus.addr = 32'h0000_0000;
        #1;
        vectors++;
        if (bus.readdata !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL ram_untouched: got %h required cafef00d", bus.readdata);
        end
    endtask

    task automatic test_reset_mid();
        store(32'h0000_0044, 32'h1111_2222);
        bus.memwrite  = 1'b1;
        bus.addr      = 32'h0000_0044;
        bus.writedata = 32'h9999_8888;
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (gpio_out !== 8'h00 || dbg_valid !== 1'b0 || dbg_count !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: got gpio=%h v=%b c=%0d required 00/0/0", gpio_out, dbg_valid, dbg_count);
        end
        tick();
        reset        = 1'b0;
        bus.memwrite = 1'b0;
        sb_q.delete();
        ovf_m = 1'b0;
        #1;
        vectors++;
        if (bus.readdata !== 32'h1111_2222) begin
            miscompares++;
            $display("FAIL store_lost_in_reset: got %h required 11112222", bus.readdata);
        end
        bus.addr = 32'hFFFF_FFF8;
        #1;
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL cycle_after_reset: got %h required 00000000", bus.readdata);
        end
    endtask

    initial begin
        bus.memwrite  = 1'b0;
        bus.addr      = 32'h0;
        bus.writedata = 32'h0;
        test_reset();
        test_ram_store();
        test_gpio();
        test_cycle();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
